xc20xx_clbcl_clbse: RTL and testbench

Cycle-based model of one XC20XX configurable logic block core: a combinational section producing two 3-input LUT outputs F and G, and a storage section producing Q. Q can be fed back into the LUTs. The block sits below the full CLB wrapper, which only adds the X/Y output muxes. Everything runs on the single fabric clock K, with a global synchronous reset.

---
 rtl/xc20xx_clb_pkg.sv | 62 ++++++
 rtl/xc20xx_clb_lut3.sv | 15 +
 rtl/xc20xx_clbcl_clbse.sv | 119 +++++++++++
 tb/tb_xc20xx_clbcl_clbse.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/xc20xx_clb_pkg.sv
// Shared constants and helpers for the XC20XX CLB core: source-select names,
// parameter legality checks and the 3-input LUT lookup.
package xc20xx_clb_pkg;

  localparam string SRC_A    = "A";
  localparam string SRC_B    = "B";
  localparam string SRC_C    = "C";
  localparam string SRC_D    = "D";
  localparam string SRC_Q    = "Q";
  localparam string SRC_F    = "F";
  localparam string SRC_G    = "G";
  localparam string SRC_K    = "K";
  localparam string SRC_NONE = "NONE";

  localparam string POL_POS  = "POSITIVE";
  localparam string POL_NEG  = "NEGATIVE";
  localparam string POL_NONE = "NONE";

  localparam string MODE_DFF    = "DFF";
  localparam string MODE_DLATCH = "DLATCH";

  function automatic bit valid_in0(input string s);
    return (s == SRC_A) || (s == SRC_B);
  endfunction

  function automatic bit valid_in1(input string s);
    return (s == SRC_B) || (s == SRC_C);
  endfunction

  function automatic bit valid_in2(input string s);
    return (s == SRC_C) || (s == SRC_D) || (s == SRC_Q);
  endfunction

  function automatic bit valid_mux_fg(input int v);
    return (v == 0) || (v == 1);
  endfunction

  function automatic bit valid_set_src(input string s);
    return (s == SRC_A) || (s == SRC_F) || (s == SRC_NONE);
  endfunction

  function automatic bit valid_rst_src(input string s);
    return (s == SRC_D) || (s == SRC_F) || (s == SRC_NONE);
  endfunction

  function automatic bit valid_clk_in(input string s);
    return (s == SRC_K) || (s == SRC_C) || (s == SRC_G);
  endfunction

  function automatic bit valid_clk_pol(input string s);
    return (s == POL_POS) || (s == POL_NEG) || (s == POL_NONE);
  endfunction

  function automatic bit valid_mode(input string s);
    return (s == MODE_DFF) || (s == MODE_DLATCH);
  endfunction

  function automatic logic lut3(input logic [7:0] init, input logic [2:0] idx);
    return init[idx];
  endfunction

endpackage

// File: rtl/xc20xx_clb_lut3.sv
// 3-input lookup table; INIT bit {in2,in1,in0} is the output.
module xc20xx_clb_lut3
  import xc20xx_clb_pkg::*;
#(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic o
);

  assign o = lut3(INIT, {in2, in1, in0});

endmodule

// File: rtl/xc20xx_clbcl_clbse.sv
// XC20XX CLB core: two 3-input LUTs (F, G) with optional 4-input combine,
// plus one storage element Q with synchronous set/reset and a selectable strobe.
module xc20xx_clbcl_clbse
  import xc20xx_clb_pkg::*;
#(
  parameter logic [7:0] F_INIT  = 8'h00,
  parameter logic [7:0] G_INIT  = 8'h00,
  parameter string      F_IN0   = "A",
  parameter string      F_IN1   = "B",
  parameter string      F_IN2   = "C",
  parameter string      G_IN0   = "A",
  parameter string      G_IN1   = "B",
  parameter string      G_IN2   = "C",
  parameter int         MUX_FG  = 0,
  parameter string      S_IN    = "A",
  parameter string      R_IN    = "D",
  parameter string      CLK_IN  = "K",
  parameter string      CLK_POL = "POSITIVE",
  parameter string      MODE    = "DFF"
) (
  input  logic K,
  input  logic RST,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic F,
  output logic G,
  output logic Q
);

  if (!valid_in0(F_IN0))        begin : g_bad_f_in0   $fatal(1, "xc20xx_clbcl_clbse: illegal F_IN0");   end
  if (!valid_in1(F_IN1))        begin : g_bad_f_in1   $fatal(1, "xc20xx_clbcl_clbse: illegal F_IN1");   end
  if (!valid_in2(F_IN2))        begin : g_bad_f_in2   $fatal(1, "xc20xx_clbcl_clbse: illegal F_IN2");   end
  if (!valid_in0(G_IN0))        begin : g_bad_g_in0   $fatal(1, "xc20xx_clbcl_clbse: illegal G_IN0");   end
  if (!valid_in1(G_IN1))        begin : g_bad_g_in1   $fatal(1, "xc20xx_clbcl_clbse: illegal G_IN1");   end
  if (!valid_in2(G_IN2))        begin : g_bad_g_in2   $fatal(1, "xc20xx_clbcl_clbse: illegal G_IN2");   end
  if (!valid_mux_fg(MUX_FG))    begin : g_bad_mux_fg  $fatal(1, "xc20xx_clbcl_clbse: illegal MUX_FG");  end
  if (!valid_set_src(S_IN))     begin : g_bad_s_in    $fatal(1, "xc20xx_clbcl_clbse: illegal S_IN");    end
  if (!valid_rst_src(R_IN))     begin : g_bad_r_in    $fatal(1, "xc20xx_clbcl_clbse: illegal R_IN");    end
  if (!valid_clk_in(CLK_IN))    begin : g_bad_clk_in  $fatal(1, "xc20xx_clbcl_clbse: illegal CLK_IN");  end
  if (!valid_clk_pol(CLK_POL))  begin : g_bad_clk_pol $fatal(1, "xc20xx_clbcl_clbse: illegal CLK_POL"); end
  if (!valid_mode(MODE))        begin : g_bad_mode    $fatal(1, "xc20xx_clbcl_clbse: illegal MODE");    end

  localparam bit F0_B      = (F_IN0 == SRC_B);
  localparam bit F1_C      = (F_IN1 == SRC_C);
  localparam bit F2_D      = (F_IN2 == SRC_D);
  localparam bit F2_Q      = (F_IN2 == SRC_Q);
  localparam bit G0_B      = (G_IN0 == SRC_B);
  localparam bit G1_C      = (G_IN1 == SRC_C);
  localparam bit G2_D      = (G_IN2 == SRC_D);
  localparam bit G2_Q      = (G_IN2 == SRC_Q);
  localparam bit COMBINE   = (MUX_FG == 1);
  localparam bit SET_A     = (S_IN == SRC_A);
  localparam bit SET_F     = (S_IN == SRC_F);
  localparam bit RST_D     = (R_IN == SRC_D);
  localparam bit RST_F     = (R_IN == SRC_F);
  localparam bit STB_K     = (CLK_IN == SRC_K);
  localparam bit STB_C     = (CLK_IN == SRC_C);
  localparam bit STB_OFF   = (CLK_POL == POL_NONE);
  localparam bit STB_POS   = (CLK_POL == POL_POS);
  localparam bit STB_LATCH = (MODE == MODE_DLATCH);

  logic q, sel_prev;
  logic fi0, fi1, fi2, gi0, gi1, gi2;
  logic f3, g3, fg4;
  logic s, r, sel, e;

  // Q feeds the LUTs only from the register, so F/G never loop combinationally.
  always_comb begin
    fi0 = F0_B ? B : A;
    fi1 = F1_C ? C : B;
    fi2 = F2_Q ? q : (F2_D ? D : C);
    gi0 = G0_B ? B : A;
    gi1 = G1_C ? C : B;
    gi2 = G2_Q ? q : (G2_D ? D : C);
  end

  xc20xx_clb_lut3 #(.INIT(F_INIT)) u_lut_f (.in0(fi0), .in1(fi1), .in2(fi2), .o(f3));
  xc20xx_clb_lut3 #(.INIT(G_INIT)) u_lut_g (.in0(gi0), .in1(gi1), .in2(gi2), .o(g3));

  always_comb begin
    fg4 = D ? g3 : f3;
    F   = COMBINE ? fg4 : f3;
    G   = COMBINE ? fg4 : g3;
  end

  always_comb begin
    s   = SET_A ? A : (SET_F ? F : 1'b0);
    r   = RST_D ? D : (RST_F ? F : 1'b0);
    sel = STB_C ? C : G;
    if (STB_OFF)
      e = 1'b0;
    else if (STB_K)
      e = 1'b1;
    else if (STB_LATCH)
      e = STB_POS ? sel : ~sel;
    else
      e = STB_POS ? (sel & ~sel_prev) : (~sel & sel_prev);
  end

  always_ff @(posedge K) begin
    if (RST) begin
      q        <= 1'b0;
      sel_prev <= 1'b0;
    end else begin
      sel_prev <= sel;
      if (r)
        q <= 1'b0;
      else if (s)
        q <= 1'b1;
      else if (e)
        q <= F;
    end
  end

  assign Q = q;

endmodule

// File: tb/tb_xc20xx_clbcl_clbse.sv
// Scoreboard bench: nine differently configured CLB cores share one input bus;
// stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_xc20xx_clbcl_clbse;

  logic K = 1'b0;
  logic RST = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic f_o[9];
  logic g_o[9];
  logic q_o[9];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  localparam int SIG_F = 0;
  localparam int SIG_G = 1;
  localparam int SIG_Q = 2;

  typedef struct {
    int    cyc;
    int    unit;
    int    sig;
    logic  want;
    string name;
  } exp_t;

  exp_t sb[$];

  // Strobe test vectors: C, A per step, then expected Q one cycle later.
  bit c_v[7]  = '{0, 1, 1, 1, 0, 0, 1};
  bit a_v[7]  = '{1, 1, 0, 0, 1, 0, 0};
  bit q4_v[7] = '{0, 1, 1, 1, 1, 1, 0};
  bit q5_v[7] = '{0, 0, 0, 0, 1, 1, 1};
  bit q6_v[7] = '{0, 1, 0, 0, 0, 0, 0};
  bit pat_v[4] = '{1, 0, 1, 1};

  always #5 K = ~K;
  always @(posedge K) cyc++;

  xc20xx_clbcl_clbse #(.F_INIT(8'hE8)) u0 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[0]), .G(g_o[0]), .Q(q_o[0]));
  xc20xx_clbcl_clbse #(.F_INIT(8'hFF), .G_INIT(8'h00), .MUX_FG(1)) u1 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[1]), .G(g_o[1]), .Q(q_o[1]));
  xc20xx_clbcl_clbse #(.F_INIT(8'hAA), .S_IN("NONE"), .R_IN("NONE")) u2 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[2]), .G(g_o[2]), .Q(q_o[2]));
  xc20xx_clbcl_clbse #(.F_INIT(8'h55), .S_IN("A"), .R_IN("D")) u3 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[3]), .G(g_o[3]), .Q(q_o[3]));
  xc20xx_clbcl_clbse #(.F_INIT(8'hAA), .S_IN("NONE"), .R_IN("NONE"), .CLK_IN("C"),
                       .CLK_POL("POSITIVE"), .MODE("DFF")) u4 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[4]), .G(g_o[4]), .Q(q_o[4]));
  xc20xx_clbcl_clbse #(.F_INIT(8'hAA), .S_IN("NONE"), .R_IN("NONE"), .CLK_IN("C"),
                       .CLK_POL("NEGATIVE"), .MODE("DFF")) u5 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[5]), .G(g_o[5]), .Q(q_o[5]));
  xc20xx_clbcl_clbse #(.F_INIT(8'hAA), .S_IN("NONE"), .R_IN("NONE"), .CLK_IN("C"),
                       .CLK_POL("POSITIVE"), .MODE("DLATCH")) u6 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[6]), .G(g_o[6]), .Q(q_o[6]));
  xc20xx_clbcl_clbse #(.F_INIT(8'h0F), .F_IN2("Q"), .S_IN("NONE"), .R_IN("NONE")) u7 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[7]), .G(g_o[7]), .Q(q_o[7]));
  xc20xx_clbcl_clbse #(.F_INIT(8'h0F), .F_IN2("Q"), .S_IN("NONE"), .R_IN("NONE"),
                       .CLK_POL("NONE")) u8 (
    .K(K), .RST(RST), .A(A), .B(B), .C(C), .D(D), .F(f_o[8]), .G(g_o[8]), .Q(q_o[8]));

  function automatic logic probe(input int unit, input int sig);
    case (sig)
      SIG_F:   return f_o[unit];
      SIG_G:   return g_o[unit];
      default: return q_o[unit];
    endcase
  endfunction

  task automatic push_exp(input int at, input int unit, input int sig, input logic want,
                          input string name);
    exp_t e;
    e.cyc  = at;
    e.unit = unit;
    e.sig  = sig;
    e.want = want;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  always @(negedge K) begin
    int i;
    logic act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        act = probe(sb[i].unit, sb[i].sig);
        n_cmp++;
        if (sb[i].cyc != cyc || act !== sb[i].want) begin
          n_err++;
          $display("FAIL %s (unit %0d, cycle %0d/%0d): got %b, expected %b",
                   sb[i].name, sb[i].unit, sb[i].cyc, cyc, act, sb[i].want);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    for (int u = 0; u < 9; u++) push_exp(cyc, u, SIG_Q, 1'b0, "reset_q");
    push_exp(cyc, 7, SIG_F, 1'b1, "reset_f_feedback");
    tick();
    RST = 1'b0;

    // Majority LUT on F, G_INIT=0
    for (int code = 0; code < 8; code++) begin
      {C, B, A} = code[2:0];
      push_exp(cyc, 0, SIG_F, ($countones(code[2:0]) >= 2), "majority_f");
      push_exp(cyc, 0, SIG_G, 1'b0, "majority_g");
      tick();
    end
    {A, B, C, D} = 4'b0000;

    // Combined 4-input mode: D selects g3 (0) over f3 (1)
    D = 1'b0;
    push_exp(cyc, 1, SIG_F, 1'b1, "mux_fg_d0_f");
    push_exp(cyc, 1, SIG_G, 1'b1, "mux_fg_d0_g");
    tick();
    D = 1'b1;
    push_exp(cyc, 1, SIG_F, 1'b0, "mux_fg_d1_f");
    push_exp(cyc, 1, SIG_G, 1'b0, "mux_fg_d1_g");
    tick();
    D = 1'b0;

    // Q follows A one cycle late; RST beats A=1
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = pat_v[i];
      push_exp(cyc + 1, 2, SIG_Q, pat_v[i], "q_follows_a");
      tick();
    end
    A = 1'b1;
    RST = 1'b1;
    push_exp(cyc + 1, 2, SIG_Q, 1'b0, "rst_over_data");
    tick();
    RST = 1'b0;
    A = 1'b0;

    // Set from A, reset from D (reset wins), else load F=~A
    A = 1'b1; D = 1'b0;
    push_exp(cyc + 1, 3, SIG_Q, 1'b1, "set_a");
    tick();
    A = 1'b1; D = 1'b1;
    push_exp(cyc + 1, 3, SIG_Q, 1'b0, "reset_wins");
    tick();
    A = 1'b0; D = 1'b0;
    push_exp(cyc + 1, 3, SIG_Q, 1'b1, "load_f");
    tick();

    // Strobe from C: DFF rising, DFF falling, latch transparent-high
    RST = 1'b1; A = 1'b0; C = 1'b0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 7; i++) begin
      C = c_v[i];
      A = a_v[i];
      push_exp(cyc + 1, 4, SIG_Q, q4_v[i], "dff_pos_c");
      push_exp(cyc + 1, 5, SIG_Q, q5_v[i], "dff_neg_c");
      push_exp(cyc + 1, 6, SIG_Q, q6_v[i], "latch_pos_c");
      tick();
    end
    {A, B, C, D} = 4'b0000;

    // Q feedback: F=~Q toggles; with no strobe Q stays 0
    RST = 1'b1;
    tick();
    push_exp(cyc, 7, SIG_F, 1'b1, "fb_f_in_reset");
    push_exp(cyc, 7, SIG_Q, 1'b0, "fb_q_in_reset");
    tick();
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_exp(cyc, 7, SIG_F, (k % 2 == 0), "fb_f_not_q");
      push_exp(cyc + 1, 7, SIG_Q, (k % 2 == 0), "fb_toggle");
      push_exp(cyc + 1, 8, SIG_Q, 1'b0, "no_strobe_hold");
      tick();
    end

    tick();
    tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
